sync_meas: RTL

// - Input-timing analyser in the TVP7002 capture domain. It consumes the latched HSYNC/VSYNC/FID.
// - Measures pixels/line and lines/field, detects interlace, flags horizontal instability.
// - Publishes a vsync toggle for the CPU status word.
// - Results feed the scanconverter line-multiplier setup and the sc_status/sc_status2 registers read by the CPU.

---
 rtl/sync_meas.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sync_meas.sv
// Input-timing analyser for the TVP7002 capture domain: line length, lines per field,
// interlace detection and horizontal lock. Optional per-field clock count under `PCNT_FRAME_EN.
`timescale 1ns/1ps

module sync_meas #(
   parameter int HCNT_W       = 12,
   parameter int VCNT_W       = 11,
   parameter int H_TOL        = 4,
   parameter int STABLE_LINES = 8
) (
   input  logic              PCLK_in,
   input  logic              hw_reset_n,
   input  logic              HSYNC_in,
   input  logic              VSYNC_in,
   input  logic              FID_in,
   input  logic              hs_pol,
   input  logic              vs_pol,
   output logic [HCNT_W-1:0] hmax,
   output logic [VCNT_W-1:0] vmax,
   output logic              ilace_flag,
   output logic              vsync_flag,
   output logic              h_unstable,
   output logic              line_stb,
   output logic [19:0]       pcnt_frame
);

   localparam int STAB_W = $clog2(STABLE_LINES + 1);

   typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2} state_t;

   logic              hs_q, hs_d, hs_prev_q, vs_q, vs_d, vs_prev_q;
   logic              hs_edge, vs_edge;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d, len_ref_q, len_ref_d, hmax_q, hmax_d, len;
   logic              hcnt_sat, in_tol;
   logic signed [HCNT_W:0] diff;
   logic [HCNT_W:0]   adiff;
   state_t            state_q, state_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic              h_unstable_q, h_unstable_d, line_stb_q, line_stb_d;
   logic [VCNT_W-1:0] vcnt_q, vcnt_d, vcnt_inc, vmax_q, vmax_d;
   logic              vflag_q, vflag_d, ilace_q, ilace_d;
   logic              fid_prev_q, fid_prev_d, fid_valid_q, fid_valid_d;

   // Polarity normalisation (1 = active) and leading-edge detection on the registered syncs.
   always_comb begin
      hs_d     = HSYNC_in ^ ~hs_pol;
      vs_d     = VSYNC_in ^ ~vs_pol;
      hs_edge  = hs_q & ~hs_prev_q;
      vs_edge  = vs_q & ~vs_prev_q;
      hcnt_sat = &hcnt_q;
      len      = hcnt_sat ? hcnt_q : hcnt_q + HCNT_W'(1);
      diff     = $signed({1'b0, len}) - $signed({1'b0, len_ref_q});
      adiff    = diff[HCNT_W] ? unsigned'(-diff) : unsigned'(diff);
      in_tol   = (adiff <= (HCNT_W+1)'(H_TOL));
   end

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      hcnt_d    = len;
      len_ref_d = len_ref_q;
      state_d   = state_q;
      stab_d    = stab_q;
      hmax_d    = hmax_q;
      if (hs_edge) begin
         hcnt_d    = '0;
         len_ref_d = len;
         case (state_q)
            UNLOCKED: begin
               if (in_tol) begin
                  stab_d  = STAB_W'(1);
                  state_d = LOCKING;
               end
            end
            LOCKING: begin
               if (!in_tol) begin
                  state_d = UNLOCKED;
                  stab_d  = '0;
               end else if (stab_q == STAB_W'(STABLE_LINES - 1)) begin
                  state_d = LOCKED;
                  hmax_d  = len;
               end else begin
                  stab_d = stab_q + STAB_W'(1);
               end
            end
            LOCKED: begin
               if (in_tol) begin
                  hmax_d = len;
               end else begin
                  state_d = UNLOCKED;
                  stab_d  = '0;
               end
            end
            default: begin
               state_d = UNLOCKED;
               stab_d  = '0;
            end
         endcase
      end else if (hcnt_sat) begin
         // No hsync for a full counter span: the line length is meaningless.
         state_d = UNLOCKED;
         stab_d  = '0;
      end
      h_unstable_d = (state_d != LOCKED);
      line_stb_d   = hs_edge;
   end

   always_comb begin
      vcnt_inc    = (&vcnt_q) ? vcnt_q : vcnt_q + VCNT_W'(1);
      vcnt_d      = hs_edge ? vcnt_inc : vcnt_q;
      vmax_d      = vmax_q;
      vflag_d     = vflag_q;
      ilace_d     = ilace_q;
      fid_prev_d  = fid_prev_q;
      fid_valid_d = fid_valid_q;
      if (vs_edge) begin
         // A coincident hsync still belongs to the field that is ending.
         vmax_d      = hs_edge ? vcnt_inc : vcnt_q;
         vcnt_d      = '0;
         vflag_d     = ~vflag_q;
         if (fid_valid_q) ilace_d = FID_in ^ fid_prev_q;
         fid_prev_d  = FID_in;
         fid_valid_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge PCLK_in or negedge hw_reset_n) begin
      if (!hw_reset_n) begin
         hs_q         <= 1'b0;
         hs_prev_q    <= 1'b0;
         vs_q         <= 1'b0;
         vs_prev_q    <= 1'b0;
         hcnt_q       <= '0;
         len_ref_q    <= '0;
         hmax_q       <= '0;
         state_q      <= UNLOCKED;
         stab_q       <= '0;
         h_unstable_q <= 1'b1;
         line_stb_q   <= 1'b0;
         vcnt_q       <= '0;
         vmax_q       <= '0;
         vflag_q      <= 1'b0;
         ilace_q      <= 1'b0;
         fid_prev_q   <= 1'b0;
         fid_valid_q  <= 1'b0;
      end else begin
         hs_q         <= hs_d;
         hs_prev_q    <= hs_q;
         vs_q         <= vs_d;
         vs_prev_q    <= vs_q;
         hcnt_q       <= hcnt_d;
         len_ref_q    <= len_ref_d;
         hmax_q       <= hmax_d;
         state_q      <= state_d;
         stab_q       <= stab_d;
         h_unstable_q <= h_unstable_d;
         line_stb_q   <= line_stb_d;
         vcnt_q       <= vcnt_d;
         vmax_q       <= vmax_d;
         vflag_q      <= vflag_d;
         ilace_q      <= ilace_d;
         fid_prev_q   <= fid_prev_d;
         fid_valid_q  <= fid_valid_d;
      end
   end

`ifdef PCNT_FRAME_EN
   logic [19:0] pcnt_q, pcnt_d, pcnt_inc, pcnt_frame_q, pcnt_frame_d;

   always_comb begin
      pcnt_inc     = (&pcnt_q) ? pcnt_q : pcnt_q + 20'd1;
      pcnt_d       = pcnt_inc;
      pcnt_frame_d = pcnt_frame_q;
      if (vs_edge) begin
         pcnt_frame_d = pcnt_inc;
         pcnt_d       = '0;
      end
   end

   always_ff @(posedge PCLK_in or negedge hw_reset_n) begin
      if (!hw_reset_n) begin
         pcnt_q       <= '0;
         pcnt_frame_q <= '0;
      end else begin
         pcnt_q       <= pcnt_d;
         pcnt_frame_q <= pcnt_frame_d;
      end
   end

   assign pcnt_frame = pcnt_frame_q;
`else
   assign pcnt_frame = 20'h0;
`endif

   assign hmax       = hmax_q;
   assign vmax       = vmax_q;
   assign ilace_flag = ilace_q;
   assign vsync_flag = vflag_q;
   assign h_unstable = h_unstable_q;
   assign line_stb   = line_stb_q;

endmodule
